// File: rtl/pipe_ctrl.sv
// Pipeline control: redirect/stall arbitration
// and external-interrupt entry sequencing.
module pipe_ctrl #(
  parameter logic [31:0] IRQ_CAUSE   = 32'h8000000B,
  parameter logic [11:0] MEPC_ADDR   = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR = 12'h342
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_ex_jump_flag,
  input  logic [31:0] i_ex_jump_addr,
  input  logic        i_ex_hold_req,
  input  logic        i_bus_hold_req,
  input  logic        i_mret,
  input  logic [31:0] i_mepc,
  input  logic [31:0] i_mtvec,
  input  logic        i_irq,
  input  logic        i_irq_enable,
  input  logic [31:0] i_id_pc,
  output logic        o_jump_flag,
  output logic [31:0] o_jump_addr,
  output logic [2:0]  o_hold_flag,
  output logic        o_csr_we,
  output logic [11:0] o_csr_waddr,
  output logic [31:0] o_csr_wdata,
  output logic        o_irq_ack
);

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  typedef enum logic [1:0] {
    IDLE,
    SAVE_EPC,
    SAVE_CAUSE,
    TRAP_JUMP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] epc_q;
  logic [31:0] epc_d;

  logic        jump_c;
  logic [31:0] addr_c;
  logic [2:0]  hold_c;
  logic        we_c;
  logic [11:0] waddr_c;
  logic [31:0] wdata_c;
  logic        ack_c;
  logic        irq_entry;

  assign irq_entry = i_irq & i_irq_enable
                   & ~i_ex_hold_req
                   & ~i_bus_hold_req
                   & ~i_mret;

  // State and captured return PC.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      epc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
    end
  end

  // Next state and unmasked control outputs.
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    jump_c  = 1'b0;
    addr_c  = 32'd0;
    hold_c  = HOLD_NONE;
    we_c    = 1'b0;
    waddr_c = 12'd0;
    wdata_c = 32'd0;
    ack_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_mret) begin
          jump_c = 1'b1;
          addr_c = i_mepc;
          hold_c = HOLD_ID;
        end else if (irq_entry) begin
          hold_c  = HOLD_ID;
          epc_d   = i_ex_jump_flag ? i_ex_jump_addr
                                   : i_id_pc;
          state_d = SAVE_EPC;
        end else if (i_ex_jump_flag) begin
          jump_c = 1'b1;
          addr_c = i_ex_jump_addr;
          hold_c = HOLD_ID;
        end else if (i_ex_hold_req) begin
          hold_c = HOLD_ID;
        end else if (i_bus_hold_req) begin
          hold_c = HOLD_PC;
        end
      end
      SAVE_EPC: begin
        hold_c = HOLD_ID;
        if (!i_bus_hold_req) begin
          we_c    = 1'b1;
          waddr_c = MEPC_ADDR;
          wdata_c = epc_q;
          state_d = SAVE_CAUSE;
        end
      end
      SAVE_CAUSE: begin
        hold_c = HOLD_ID;
        if (!i_bus_hold_req) begin
          we_c    = 1'b1;
          waddr_c = MCAUSE_ADDR;
          wdata_c = IRQ_CAUSE;
          state_d = TRAP_JUMP;
        end
      end
      TRAP_JUMP: begin
        hold_c = HOLD_ID;
        if (!i_bus_hold_req) begin
          jump_c  = 1'b1;
          addr_c  = {i_mtvec[31:2], 2'b00};
          ack_c   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are silenced while reset is asserted.
  always_comb begin
    o_jump_flag = 1'b0;
    o_jump_addr = 32'd0;
    o_hold_flag = HOLD_NONE;
    o_csr_we    = 1'b0;
    o_csr_waddr = 12'd0;
    o_csr_wdata = 32'd0;
    o_irq_ack   = 1'b0;
    if (i_reset_n) begin
      o_jump_flag = jump_c;
      o_jump_addr = addr_c;
      o_hold_flag = hold_c;
      o_csr_we    = we_c;
      o_csr_waddr = waddr_c;
      o_csr_wdata = wdata_c;
      o_irq_ack   = ack_c;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: queue-based trap model
// plus directed literal checks.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ex_jump;
  logic [31:0] ex_addr;
  logic        ex_hold;
  logic        bus_hold;
  logic        mret;
  logic [31:0] mepc;
  logic [31:0] mtvec;
  logic        irq;
  logic        irq_en;
  logic [31:0] id_pc;
  logic        jump;
  logic [31:0] jaddr;
  logic [2:0]  hold;
  logic        we;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic        ack;

  int checks = 0;
  int errors = 0;

  pipe_ctrl dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_ex_jump_flag (ex_jump),
    .i_ex_jump_addr (ex_addr),
    .i_ex_hold_req  (ex_hold),
    .i_bus_hold_req (bus_hold),
    .i_mret         (mret),
    .i_mepc         (mepc),
    .i_mtvec        (mtvec),
    .i_irq          (irq),
    .i_irq_enable   (irq_en),
    .i_id_pc        (id_pc),
    .o_jump_flag    (jump),
    .o_jump_addr    (jaddr),
    .o_hold_flag    (hold),
    .o_csr_we       (we),
    .o_csr_waddr    (waddr),
    .o_csr_wdata    (wdata),
    .o_irq_ack      (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pending trap work: each entry is one step
  // still owed (0 mepc write, 1 mcause write, 2 jump).
  typedef struct {
    int          kind;
    logic [31:0] data;
  } act_t;
  act_t pend[$];

  // Per-cycle model compare, then advance the model
  // across the coming rising edge.
  always @(negedge clk) begin
    logic        e_j;
    logic [31:0] e_a;
    logic [2:0]  e_h;
    logic        e_we;
    logic [11:0] e_wa;
    logic [31:0] e_wd;
    logic        e_ack;
    logic        pop;
    logic        entry;
    e_j = 0; e_a = 0; e_h = 0; e_we = 0;
    e_wa = 0; e_wd = 0; e_ack = 0;
    pop = 0; entry = 0;
    if (!rst_n) begin
      pend.delete();
    end else if (pend.size() != 0) begin
      e_h = 3;
      if (!bus_hold) begin
        pop = 1;
        case (pend[0].kind)
          0: begin e_we = 1; e_wa = 12'h341; e_wd = pend[0].data; end
          1: begin e_we = 1; e_wa = 12'h342; e_wd = 32'h8000000B; end
          default: begin
            e_j = 1; e_a = mtvec & ~32'd3; e_ack = 1;
          end
        endcase
      end
    end else if (mret) begin
      e_j = 1; e_a = mepc; e_h = 3;
    end else if (irq && irq_en && !ex_hold && !bus_hold) begin
      e_h = 3; entry = 1;
    end else if (ex_jump) begin
      e_j = 1; e_a = ex_addr; e_h = 3;
    end else begin
      e_h = ex_hold ? 3 : (bus_hold ? 1 : 0);
    end
    checks++;
    if ({jump, jaddr, hold, we, waddr, wdata, ack} !==
        {e_j, e_a, e_h, e_we, e_wa, e_wd, e_ack}) begin
      errors++;
      $display("FAIL cyc t=%0t got j=%b a=%h h=%0d we=%b wa=%h wd=%h ack=%b exp j=%b a=%h h=%0d we=%b wa=%h wd=%h ack=%b",
               $time, jump, jaddr, hold, we, waddr, wdata, ack,
               e_j, e_a, e_h, e_we, e_wa, e_wd, e_ack);
    end
    if (pop) void'(pend.pop_front());
    if (entry) begin
      pend.push_back('{0, ex_jump ? ex_addr : id_pc});
      pend.push_back('{1, 32'd0});
      pend.push_back('{2, 32'd0});
    end
  end

  task automatic lit(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; ex_jump = 1; ex_addr = 32'h100;
    ex_hold = 0; bus_hold = 0; mret = 0;
    mepc = 0; mtvec = 0; irq = 0; irq_en = 0;
    id_pc = 0;
    settle;
    lit("rst_jump", {31'd0, jump}, 0);
    lit("rst_addr", jaddr, 0);
    lit("rst_hold", {29'd0, hold}, 0);

    tick; rst_n = 1;
    settle;
    lit("jmp_flag", {31'd0, jump}, 1);
    lit("jmp_addr", jaddr, 32'h100);
    lit("jmp_hold", {29'd0, hold}, 3);

    tick; mret = 1; mepc = 32'h40;
    settle;
    lit("mret_addr", jaddr, 32'h40);

    tick; mret = 0; ex_jump = 0;
    ex_hold = 1; bus_hold = 1;
    settle;
    lit("both_hold", {29'd0, hold}, 3);
    lit("both_jump", {31'd0, jump}, 0);
    tick; ex_hold = 0;
    settle;
    lit("bus_hold", {29'd0, hold}, 1);
    tick; bus_hold = 0;
    settle;
    lit("no_hold", {29'd0, hold}, 0);

    tick; irq = 1; irq_en = 1;
    id_pc = 32'h2C; mtvec = 32'h81;
    settle;
    lit("entry_hold", {29'd0, hold}, 3);
    lit("entry_we", {31'd0, we}, 0);
    tick; irq = 0;
    settle;
    lit("epc_waddr", {20'd0, waddr}, 32'h341);
    lit("epc_wdata", wdata, 32'h2C);
    tick;
    settle;
    lit("cause_waddr", {20'd0, waddr}, 32'h342);
    lit("cause_wdata", wdata, 32'h8000000B);
    tick;
    settle;
    lit("trap_addr", jaddr, 32'h80);
    lit("trap_ack", {31'd0, ack}, 1);
    lit("trap_hold", {29'd0, hold}, 3);
    tick;
    settle;
    lit("post_ack", {31'd0, ack}, 0);
    lit("post_hold", {29'd0, hold}, 0);

    tick; irq = 1; ex_jump = 1; ex_addr = 32'h200;
    settle;
    lit("ej_entry_jump", {31'd0, jump}, 0);
    tick; irq = 0; ex_jump = 0;
    settle;
    lit("ej_mepc", wdata, 32'h200);
    tick; tick; tick;

    irq = 1; ex_hold = 1;
    for (int i = 0; i < 5; i++) begin
      settle;
      lit("defer_we", {31'd0, we}, 0);
      tick;
    end
    ex_hold = 0;
    settle;
    lit("late_entry_we", {31'd0, we}, 0);
    tick; irq = 0;
    settle;
    lit("late_epc", wdata, 32'h2C);
    tick; tick; tick;

    irq = 1; id_pc = 32'h64;
    tick; irq = 0;
    tick; bus_hold = 1;
    for (int i = 0; i < 3; i++) begin
      settle;
      lit("frz_we", {31'd0, we}, 0);
      lit("frz_hold", {29'd0, hold}, 3);
      tick;
    end
    bus_hold = 0;
    settle;
    lit("frz_cause", {20'd0, waddr}, 32'h342);
    tick;
    settle;
    lit("frz_ack", {31'd0, ack}, 1);
    tick;

    irq = 1; id_pc = 32'h10;
    tick; irq = 0; rst_n = 0;
    settle;
    lit("rst_mid_we", {31'd0, we}, 0);
    lit("rst_mid_hold", {29'd0, hold}, 0);
    tick; rst_n = 1;
    settle;
    lit("rst_idle_we", {31'd0, we}, 0);
    tick;
    settle;
    lit("rst_no_resume", {31'd0, we}, 0);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
